// File: rtl/ball_pkg.sv
// Direction encodings shared by the tilt front end and the ball/map stage.
package ball_pkg;

  typedef enum logic [3:0] {
    DIR_NONE  = 4'b0000,
    DIR_UP    = 4'b0001,
    DIR_DOWN  = 4'b0010,
    DIR_LEFT  = 4'b0100,
    DIR_RIGHT = 4'b1000
  } dir_t;

  // X axis: positive is RIGHT; Y axis: positive is DOWN (screen coordinates).
  function automatic dir_t axis_dir(input logic is_x, input logic neg);
    if (is_x) return neg ? DIR_LEFT : DIR_RIGHT;
    else      return neg ? DIR_UP   : DIR_DOWN;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: update is high for one cycle every DIV cycles,
// first at cycle DIV-1 after reset release.
module tick_gen #(
  parameter int unsigned DIV = 5
) (
  input  logic clk,
  input  logic reset,
  output logic update
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign update = (cnt == LAST);

endmodule

// File: rtl/tilt_to_movement.sv
// Accelerometer tilt to one-hot movement: deadzone, dominant axis, debounce,
// sample watchdog. Define TILT_HYST_EN to lower the release threshold by HYST.
module tilt_to_movement
  import ball_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY_HZ       = 100000000,
  parameter int unsigned UPDATE_FREQUENCY_HZ    = 30,
  parameter int unsigned SIMULATE               = 0,
  parameter int unsigned SIMULATE_FREQUENCY_CNT = 5,
  parameter int unsigned ACCEL_WIDTH            = 12,
  parameter int unsigned DEADZONE               = 200,
  parameter int unsigned HYST                   = 50,
  parameter int unsigned DEBOUNCE_SAMPLES       = 3,
  parameter int unsigned SAMPLE_TIMEOUT         = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ACCEL_WIDTH-1:0] accel_x,
  input  logic [ACCEL_WIDTH-1:0] accel_y,
  input  logic                   sample_valid,
  output logic [3:0]             movement,
  output logic                   update,
  output logic                   stale
);

  localparam int unsigned DIV = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                                : CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ;
  localparam int MW  = ACCEL_WIDTH - 1;
  localparam int DBW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int WDW = $clog2(SAMPLE_TIMEOUT + 1);
  localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE_SAMPLES);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(SAMPLE_TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(SAMPLE_TIMEOUT - 1);

`ifdef TILT_HYST_EN
  if (HYST >= DEADZONE) begin : g_bad_hyst
    $error("HYST must be smaller than DEADZONE");
  end
`endif

  // |v| at ACCEL_WIDTH+1 bits so the most negative code does not wrap, then clamp.
  function automatic logic [MW-1:0] abs_sat(input logic [ACCEL_WIDTH-1:0] v);
    logic [ACCEL_WIDTH:0] ext;
    logic [ACCEL_WIDTH:0] mag;
    ext = {v[ACCEL_WIDTH-1], v};
    mag = ext[ACCEL_WIDTH] ? (~ext + (ACCEL_WIDTH+1)'(1)) : ext;
    return (mag[ACCEL_WIDTH:MW] != 2'b00) ? {MW{1'b1}} : mag[MW-1:0];
  endfunction

  logic          s1_valid;
  logic [MW-1:0] s1_mag_x, s1_mag_y;
  logic          s1_neg_x, s1_neg_y;

  dir_t           committed, prev_cand, cand, dom_dir;
  logic [DBW-1:0] db_cnt, cnt_next;
  logic [WDW-1:0] wd_cnt;
  logic           x_dom, expire;
  logic [MW-1:0]  dom_mag;
  int unsigned    thr;

  always_comb begin
    x_dom   = s1_mag_x > s1_mag_y;
    dom_mag = x_dom ? s1_mag_x : s1_mag_y;
    dom_dir = axis_dir(x_dom, x_dom ? s1_neg_x : s1_neg_y);
    thr     = DEADZONE;
`ifdef TILT_HYST_EN
    if (dom_dir == committed) thr = DEADZONE - HYST;
`endif
    cand = (32'(dom_mag) > thr) ? dom_dir : DIR_NONE;
    if (cand != prev_cand)    cnt_next = DBW'(1);
    else if (db_cnt == DB_MAX) cnt_next = db_cnt;
    else                       cnt_next = db_cnt + DBW'(1);
  end

  // A strobe on the expiry cycle keeps the committed direction alive.
  assign expire = !sample_valid && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_mag_x  <= '0;
      s1_mag_y  <= '0;
      s1_neg_x  <= 1'b0;
      s1_neg_y  <= 1'b0;
      committed <= DIR_NONE;
      prev_cand <= DIR_NONE;
      db_cnt    <= '0;
      wd_cnt    <= '0;
      stale     <= 1'b1;
    end else begin
      s1_valid <= sample_valid;
      if (sample_valid) begin
        s1_mag_x <= abs_sat(accel_x);
        s1_mag_y <= abs_sat(accel_y);
        s1_neg_x <= accel_x[ACCEL_WIDTH-1];
        s1_neg_y <= accel_y[ACCEL_WIDTH-1];
      end

      if (sample_valid) begin
        wd_cnt <= '0;
        stale  <= 1'b0;
      end else if (wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + WDW'(1);
      end
      if (expire) stale <= 1'b1;

      if (s1_valid) prev_cand <= cand;
      if (expire) begin
        committed <= DIR_NONE;
        db_cnt    <= '0;
      end else if (s1_valid) begin
        db_cnt <= cnt_next;
        if (cnt_next == DB_MAX) committed <= cand;
      end
    end
  end

  assign movement = committed;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .update (update)
  );

endmodule

// File: tb/tb_tilt_to_movement.sv
// Bench for tilt_to_movement: directed corner cases plus randomized sample
// streams against an arithmetic reference model (honours TILT_HYST_EN).
module tb_tilt_to_movement;

  localparam int TO = 20;
  localparam int DB = 3;
  localparam int DZ = 200;
  localparam int HY = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] accel_x = '0;
  logic [11:0] accel_y = '0;
  logic [3:0]  movement;
  logic        update;
  logic        stale;

  always #5 clk = ~clk;

  tilt_to_movement #(
    .CLK_FREQUENCY_HZ       (100000000),
    .UPDATE_FREQUENCY_HZ    (30),
    .SIMULATE               (1),
    .SIMULATE_FREQUENCY_CNT (5),
    .ACCEL_WIDTH            (12),
    .DEADZONE               (DZ),
    .HYST                   (HY),
    .DEBOUNCE_SAMPLES       (DB),
    .SAMPLE_TIMEOUT         (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .accel_x      (accel_x),
    .accel_y      (accel_y),
    .sample_valid (sample_valid),
    .movement     (movement),
    .update       (update),
    .stale        (stale)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [3:0] m_comm;
  logic [3:0] m_hist[$];
  bit         m_stale;
  int         m_wd;

  function automatic int mag(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return (a > 2047) ? 2047 : a;
  endfunction

  function automatic logic [3:0] classify(input int x, input int y, input logic [3:0] comm);
    int ax, ay, m, thr;
    logic [3:0] d;
    ax = mag(x);
    ay = mag(y);
    if (ax > ay) begin
      m = ax;
      d = (x < 0) ? 4'b0100 : 4'b1000;
    end else begin
      m = ay;
      d = (y < 0) ? 4'b0001 : 4'b0010;
    end
    thr = DZ;
`ifdef TILT_HYST_EN
    if (d == comm) thr = DZ - HY;
`endif
    return (m > thr) ? d : 4'b0000;
  endfunction

  task automatic model_reset();
    m_comm  = 4'b0000;
    m_hist.delete();
    m_stale = 1'b1;
    m_wd    = 0;
  endtask

  task automatic model_edges(input int k);
    for (int i = 0; i < k; i++) begin
      if (m_wd < TO) begin
        m_wd++;
        if (m_wd == TO) begin
          m_comm  = 4'b0000;
          m_hist.delete();
          m_stale = 1'b1;
        end
      end
    end
  endtask

  task automatic model_sample(input int x, input int y);
    logic [3:0] c;
    int run;
    c = classify(x, y, m_comm);
    m_hist.push_back(c);
    if (m_hist.size() > DB) void'(m_hist.pop_front());
    run = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (m_hist[i] == c) run++;
      else break;
    end
    if (run >= DB) m_comm = c;
    m_stale = 1'b0;
  endtask

  // Called #1 after a posedge; strobe lands on the next edge, result checked one edge later.
  task automatic send(input int x, input int y);
    sample_valid = 1'b1;
    accel_x = 12'(x);
    accel_y = 12'(y);
    @(posedge clk);
    #1 sample_valid = 1'b0;
    m_wd = 0;
    @(posedge clk);
    #1;
    model_edges(1);
    model_sample(x, y);
    chk("send_mov", movement, m_comm);
    chk("send_stale", stale, m_stale);
  endtask

  task automatic send_n(input int x, input int y, input int n);
    for (int i = 0; i < n; i++) send(x, y);
  endtask

  task automatic idle(input int k);
    if (k > 0) repeat (k) @(posedge clk);
    #1;
    model_edges(k);
    chk("idle_mov", movement, m_comm);
    chk("idle_stale", stale, m_stale);
  endtask

  // Holds reset for two edges, checks reset values, then checks tick phase.
  task automatic do_reset(input logic pending_sample);
    reset = 1'b0;
    sample_valid = pending_sample;
    accel_x = 12'd300;
    accel_y = 12'd0;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    chk("rst_mov", movement, 0);
    chk("rst_stale", stale, 1);
    chk("rst_upd", update, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk($sformatf("tick_c%0d", c), update, ((c % 5) == 4) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    model_edges(15);
    chk("post_rst_mov", movement, 0);
  endtask

  initial begin
    model_reset();
    #1;
    do_reset(1'b0);

    // Debounce: nothing after two samples, RIGHT after the third
    send_n(300, 0, 2);
    chk("deb_two", movement, 4'b0000);
    send(300, 0);
    chk("deb_three", movement, 4'b1000);

    send_n(-150, 250, 3);
    chk("down", movement, 4'b0010);
    send_n(250, -250, 3);
    chk("tie_up", movement, 4'b0001);

    // Hysteresis release
    send_n(300, 0, 3);
    send_n(170, 0, 3);
`ifdef TILT_HYST_EN
    chk("hyst170", movement, 4'b1000);
`else
    chk("hyst170", movement, 4'b0000);
`endif
    send_n(140, 0, 3);
    chk("hyst140", movement, 4'b0000);

    // Saturation of the most negative code
    send_n(-2048, 0, 3);
    chk("sat_left", movement, 4'b0100);
    send_n(-2048, 2047, 3);
    chk("sat_tie", movement, 4'b0010);

    // Deadzone boundary
    send_n(0, -201, 3);
    send_n(200, 0, 3);
    chk("dz_200", movement, 4'b0000);
    send_n(201, 0, 3);
    chk("dz_201", movement, 4'b1000);

    // Watchdog expiry at cycle TO after the last strobe
    send_n(0, -300, 3);
    idle(TO - 2);
    chk("wd_before", stale, 0);
    chk("wd_before_mov", movement, 4'b0001);
    idle(1);
    chk("wd_stale", stale, 1);
    chk("wd_mov", movement, 4'b0000);
    send(0, -300);
    chk("wd_clear", stale, 0);

    // Strobe coinciding with expiry: sample wins
    send_n(0, -300, 3);
    idle(TO - 2);
    send(0, -300);
    chk("wd_race_mov", movement, 4'b0001);
    chk("wd_race_stale", stale, 0);

    // Reset mid-run with a strobe on the reset edge
    send_n(-400, 0, 3);
    do_reset(1'b1);
    idle(2);
    chk("rst_discard", movement, 4'b0000);

    // Randomized streams
    for (int it = 0; it < 80; it++) begin
      int x, y, r;
      if ($urandom_range(0, 1) == 0) begin
        x = int'($urandom_range(0, 4095)) - 2048;
        y = int'($urandom_range(0, 4095)) - 2048;
      end else begin
        x = int'($urandom_range(0, 600)) - 300;
        y = int'($urandom_range(0, 600)) - 300;
      end
      r = int'($urandom_range(1, 4));
      send_n(x, y, r);
      if ($urandom_range(0, 5) == 0) idle(int'($urandom_range(0, 30)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tilt_to_movement.md
# tilt_to_movement

Converts raw signed accelerometer X/Y samples into the one-hot `movement` command and the `update` tick consumed by the ball stage. Applies a deadzone, optional hysteresis, dominant-axis selection and sample-count debounce, and forces the ball idle when the sensor stops delivering samples. Sits between the accelerometer SPI reader and the ball/map stage.

## Interface
- `CLK_FREQUENCY_HZ`, 100000000, system clock rate
- `UPDATE_FREQUENCY_HZ`, 30, `update` tick rate
- `SIMULATE`, 0, 1 selects `SIMULATE_FREQUENCY_CNT` as tick divider
- `SIMULATE_FREQUENCY_CNT`, 5, tick divider in simulation
- `ACCEL_WIDTH`, 12, sample width (two's complement)
- `DEADZONE`, 200, magnitude required to enter a direction
- `HYST`, 50, release margin (only with `TILT_HYST_EN`)
- `DEBOUNCE_SAMPLES`, 3, consecutive equal classifications to commit
- `SAMPLE_TIMEOUT`, 1000000, clk cycles without a sample before going stale
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low
- `accel_x`  in  ACCEL_WIDTH  signed X tilt
- `accel_y`  in  ACCEL_WIDTH  signed Y tilt
- `sample_valid`  in  1  one-cycle strobe; `accel_x`/`accel_y` valid
- `movement`  out  4  one-hot {RIGHT,LEFT,DOWN,UP} = bits 3..0, or 0
- `update`  out  1  one-cycle tick
- `stale`  out  1  no sample within `SAMPLE_TIMEOUT`

## Operation
- Reset (`reset`=0 at clk edge): `movement`=0, `update`=0, `stale`=1, all counters 0, committed direction NONE.
- Stage 1: on `sample_valid`, register both samples; abs value computed at ACCEL_WIDTH+1 bits, then saturated to 2^(ACCEL_WIDTH-1)-1 (so -2048 gives 2047).
- Stage 2 classification: dominant axis = X if |x| > |y|, else Y (tie → Y). Sign maps: +x RIGHT, -x LEFT, +y DOWN, -y UP. Candidate = that direction if dominant magnitude > threshold, else NONE.
- Threshold = `DEADZONE`; with `TILT_HYST_EN`, threshold = `DEADZONE-HYST` when candidate direction equals committed direction.
- Debounce: candidate equal to previous candidate increments a saturating count, otherwise count=1. When count reaches `DEBOUNCE_SAMPLES`, committed direction ← candidate (NONE included). Committed direction drives `movement` directly, held between samples.
- Watchdog: counts cycles since last `sample_valid`; on reaching `SAMPLE_TIMEOUT`: `stale`=1, committed=NONE, debounce count=0; counter holds. Next `sample_valid` clears counter and `stale`.
- Tick: divider DIV = SIMULATE ? `SIMULATE_FREQUENCY_CNT` : CLK_FREQUENCY_HZ/UPDATE_FREQUENCY_HZ; `update` high for one cycle when counter = DIV-1, then wraps to 0. Free-running, independent of samples and `stale`.

## Timing
- `sample_valid` at edge N → samples registered N → classification/debounce/`movement` updated edge N+1; `movement` visible after edge N+1 (latency 2 edges).
- Minimum `sample_valid` spacing: 2 cycles; a strobe arriving while stage 2 busy overwrites stage 1 (last sample wins).
- `movement` changes only at commit or watchdog expiry; never glitches through zero between two directions.
- Simultaneous `sample_valid` and watchdog expiry: sample wins; `stale` cleared, no forced NONE.
- First `update` pulse at cycle DIV-1 after reset release.
- Reset mid-operation: all state returns to reset values on that edge, pipeline sample discarded.

## Configuration
- `TILT_HYST_EN` defined: release threshold `DEADZONE-HYST` for the committed direction; `HYST` must be < `DEADZONE`.
- Undefined: single threshold `DEADZONE`; `HYST` ignored.

## Structure
- Shared package `ball_pkg`: direction encodings UP=4'b0001, DOWN=4'b0010, LEFT=4'b0100, RIGHT=4'b1000, NONE=4'b0000; shared with the ball stage.
- Sub-module `tick_gen` (parameterised divider producing `update`).

## Test plan
- DEBOUNCE_SAMPLES=3, DEADZONE=200: three samples x=+300,y=0 → `movement`=4'b1000 two edges after third strobe; after only two, still 0.
- x=-150,y=+250 ×3 → DOWN (4'b0010); x=+250,y=-250 ×3 → UP (tie → Y).
- With `TILT_HYST_EN`, HYST=50: commit RIGHT at x=300, then x=170 ×3 → stays RIGHT; x=140 ×3 → 0. Without macro, x=170 ×3 → 0.
- x=-2048 ×3 → LEFT, no overflow; magnitude saturates at 2047.
- SAMPLE_TIMEOUT=20: commit UP, stop strobes → at cycle 20 `stale`=1, `movement`=0; next strobe clears `stale`.
- SIMULATE=1, SIMULATE_FREQUENCY_CNT=5: `update` pulses at cycles 4, 9, 14 after reset release; assert `reset`=0 mid-run → all outputs reset that edge.
